// File: rtl/mips_pkg.sv
// Shared MIPS definitions: default datapath widths, architectural register
// numbers and the destination-register select used ahead of the register file.
package mips_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_GP   = 28;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_RA   = 31;

  typedef enum logic [1:0] {
    REG_DST_RT = 2'b00,
    REG_DST_RD = 2'b01,
    REG_DST_RA = 2'b10
  } reg_dst_e;

  // Destination-select mux: I-type writes rt, R-type writes rd, jal writes $ra.
  function automatic logic [ADDR_W_DEF-1:0] dest_reg(input reg_dst_e sel,
                                                     input logic [ADDR_W_DEF-1:0] rt,
                                                     input logic [ADDR_W_DEF-1:0] rd);
    logic [ADDR_W_DEF-1:0] r;
    r = rt;
    case (sel)
      REG_DST_RT: r = rt;
      REG_DST_RD: r = rd;
      REG_DST_RA: r = ADDR_W_DEF'(REG_RA);
      default:    r = rt;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/banco_registradores_bypass_mux.sv
// Per-port write-before-read forwarding: selects the in-flight write data when
// the read address matches an active write; address 0 always reads zero.
module bypass_mux
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] stored_data,
  output logic [DATA_W-1:0] rd_data
);

  always_comb begin
    rd_data = stored_data;
    if (rd_addr == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
    end else if (wr_en && (rd_addr == wr_addr)) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/banco_registradores.sv
// MIPS register file: 2 combinational read ports with write bypass, 1 write
// port, a non-bypassed debug port, and per-register reset values for $gp/$sp.
module banco_registradores
  import mips_pkg::*;
#(
  parameter int unsigned        DATA_W  = DATA_W_DEF,
  parameter int unsigned        ADDR_W  = ADDR_W_DEF,
  parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(32'h0000_3FFC),
  parameter logic [DATA_W-1:0]  GP_INIT = DATA_W'(32'h0000_1800)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [ADDR_W-1:0] dbg_reg,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic              we;
  logic              fwd_en;

  // Writes to register 0 are dropped here, so its flop holds its reset zero.
  assign we     = reg_write && (write_reg != ADDR_W'(REG_ZERO));
  assign fwd_en = we && rst_n;

  // Flop array rather than RAM: $gp and $sp need non-zero asynchronous reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (i == REG_GP) begin
          regs[i] <= GP_INIT;
        end else if (i == REG_SP) begin
          regs[i] <= SP_INIT;
        end else begin
          regs[i] <= '0;
        end
      end
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (we && (write_reg == ADDR_W'(i))) begin
          regs[i] <= write_data;
        end
      end
    end
  end

  bypass_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass1 (
    .rd_addr     (read_reg1),
    .wr_en       (fwd_en),
    .wr_addr     (write_reg),
    .wr_data     (write_data),
    .stored_data (regs[read_reg1]),
    .rd_data     (read_data1)
  );

  bypass_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bypass2 (
    .rd_addr     (read_reg2),
    .wr_en       (fwd_en),
    .wr_addr     (write_reg),
    .wr_data     (write_data),
    .stored_data (regs[read_reg2]),
    .rd_data     (read_data2)
  );

  assign dbg_data = regs[dbg_reg];

endmodule

// File: tb/tb_banco_registradores.sv
// Self-checking bench for banco_registradores: directed vector table, reset and
// hold sequences, then a random write/read run against a reference array.
module tb_banco_registradores;

  logic        clk;
  logic        clk_en;
  logic        rst_n;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [4:0]  dbg_reg;
  logic [31:0] dbg_data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [4:0]  dbg;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl [11];

  banco_registradores #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .SP_INIT (32'h0000_3FFC),
    .GP_INIT (32'h0000_1800)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .dbg_reg    (dbg_reg),
    .dbg_data   (dbg_data)
  );

  initial begin
    clk    = 1'b0;
    clk_en = 1'b1;
  end
  always #10 clk = clk_en ? ~clk : clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model[28] = 32'h0000_1800;
    model[29] = 32'h0000_3FFC;
  endtask

  initial begin
    tbl[0]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd29, 5'd28, 5'd0,  32'h0000_3FFC, 32'h0000_1800, 32'h0000_0000};
    tbl[1]  = '{1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  5'd8,  5'd8,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[2]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd8,  5'd0,  5'd8,  32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  5'd0,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    tbl[4]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd0,  5'd8,  5'd0,  32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_0000};
    tbl[5]  = '{1'b1, 5'd9,  32'h1234_5678, 5'd9,  5'd9,  5'd9,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000};
    tbl[6]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd9,  5'd29, 5'd9,  32'h1234_5678, 32'h0000_3FFC, 32'h1234_5678};
    tbl[7]  = '{1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd30, 5'd31, 32'hCAFE_F00D, 32'h0000_0000, 32'h0000_0000};
    tbl[8]  = '{1'b1, 5'd30, 32'h1111_0000, 5'd31, 5'd30, 5'd30, 32'hCAFE_F00D, 32'h1111_0000, 32'h0000_0000};
    tbl[9]  = '{1'b1, 5'd1,  32'h0000_0001, 5'd30, 5'd1,  5'd31, 32'h1111_0000, 32'h0000_0001, 32'hCAFE_F00D};
    tbl[10] = '{1'b0, 5'd0,  32'h0000_0000, 5'd1,  5'd9,  5'd1,  32'h0000_0001, 32'h1234_5678, 32'h0000_0001};

    rst_n      = 1'b0;
    reg_write  = 1'b0;
    write_reg  = '0;
    write_data = '0;
    read_reg1  = '0;
    read_reg2  = '0;
    dbg_reg    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed table: inputs driven at negedge, outputs sampled before the next posedge.
    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      reg_write  = tbl[v].we;
      write_reg  = tbl[v].wa;
      write_data = tbl[v].wd;
      read_reg1  = tbl[v].r1;
      read_reg2  = tbl[v].r2;
      dbg_reg    = tbl[v].dbg;
      #1;
      chk($sformatf("vec%0d_rd1", v), read_data1, tbl[v].e1);
      chk($sformatf("vec%0d_rd2", v), read_data2, tbl[v].e2);
      chk($sformatf("vec%0d_dbg", v), dbg_data,   tbl[v].ed);
    end

    // Register 0 stays zero in later cycles after the discarded write.
    @(negedge clk);
    reg_write = 1'b0;
    read_reg1 = 5'd0;
    dbg_reg   = 5'd0;
    #1;
    chk("r0_later_rd1", read_data1, 32'h0);
    chk("r0_later_dbg", dbg_data,   32'h0);

    // Reset mid-operation: $sp overwritten, then reset pulsed between edges.
    @(negedge clk);
    reg_write  = 1'b1;
    write_reg  = 5'd29;
    write_data = 32'hA5A5_A5A5;
    read_reg1  = 5'd29;
    #1;
    chk("sp_bypass", read_data1, 32'hA5A5_A5A5);
    @(negedge clk);
    reg_write = 1'b0;
    dbg_reg   = 5'd29;
    #1;
    chk("sp_written", dbg_data, 32'hA5A5_A5A5);
    clk_en = 1'b0;
    #2;
    rst_n      = 1'b0;
    reg_write  = 1'b1;
    write_reg  = 5'd5;
    write_data = 32'h0000_0077;
    read_reg1  = 5'd29;
    read_reg2  = 5'd28;
    #1;
    chk("rst_sp", read_data1, 32'h0000_3FFC);
    chk("rst_gp", read_data2, 32'h0000_1800);
    read_reg2 = 5'd5;
    #1;
    chk("rst_no_bypass", read_data2, 32'h0);
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i);
      dbg_reg   = 5'(i);
      #1;
      chk($sformatf("rst_rd1_r%0d", i), read_data1,
          (i == 29) ? 32'h0000_3FFC : (i == 28) ? 32'h0000_1800 : 32'h0);
      chk($sformatf("rst_dbg_r%0d", i), dbg_data,
          (i == 29) ? 32'h0000_3FFC : (i == 28) ? 32'h0000_1800 : 32'h0);
    end
    rst_n  = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    dbg_reg = 5'd5;
    #1;
    chk("first_write_after_rst", dbg_data, 32'h0000_0077);
    dbg_reg = 5'd8;
    #1;
    chk("r8_cleared_by_rst", dbg_data, 32'h0);

    model_reset();
    model[5] = 32'h0000_0077;

    // Hold: no writes with random addresses/data.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      reg_write  = 1'b0;
      write_reg  = (c % 7 == 0) ? 'x : 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = 5'($urandom_range(0, 31));
      read_reg2  = 5'($urandom_range(0, 31));
      #1;
      chk("hold_rd1", read_data1, model[read_reg1]);
      chk("hold_rd2", read_data2, model[read_reg2]);
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      dbg_reg = 5'(i);
      #1;
      chk($sformatf("hold_dbg_r%0d", i), dbg_data, model[i]);
    end

    // Random write/read against the reference array.
    for (int c = 0; c < 1000; c++) begin
      logic [31:0] e1, e2;
      @(negedge clk);
      reg_write  = ($urandom_range(0, 3) != 0);
      write_reg  = 5'($urandom_range(0, 31));
      write_data = $urandom;
      read_reg1  = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom_range(0, 31));
      read_reg2  = ($urandom_range(0, 2) == 0) ? write_reg : 5'($urandom_range(0, 31));
      dbg_reg    = ($urandom_range(0, 1) == 0) ? write_reg : 5'($urandom_range(0, 31));
      e1 = (read_reg1 == 0) ? 32'h0 :
           (reg_write && write_reg != 0 && write_reg == read_reg1) ? write_data : model[read_reg1];
      e2 = (read_reg2 == 0) ? 32'h0 :
           (reg_write && write_reg != 0 && write_reg == read_reg2) ? write_data : model[read_reg2];
      #1;
      chk("rand_rd1", read_data1, e1);
      chk("rand_rd2", read_data2, e2);
      chk("rand_dbg", dbg_data,   model[dbg_reg]);
      if (reg_write && write_reg != 0) model[write_reg] = write_data;
    end

    @(negedge clk);
    reg_write = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/banco_registradores.md
BANCO_REGISTRADORES -- requirements
Module: banco_registradores

Interface
REQ-001 Parameter DATA_W, default 32, register and data width in bits.
REQ-002 Parameter ADDR_W, default 5, register address width; depth is 2**ADDR_W = 32 registers.
REQ-003 Parameter SP_INIT, default 32'h0000_3FFC, reset value of register 29 ($sp).
REQ-004 Parameter GP_INIT, default 32'h0000_1800, reset value of register 28 ($gp).
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 Port reg_write  input  1  write enable from the control unit.
REQ-008 Port write_reg  input  ADDR_W  destination register, driven by the destination-select mux (rt/rd).
REQ-009 Port write_data  input  DATA_W  value to write.
REQ-010 Port read_reg1  input  ADDR_W  rs address.
REQ-011 Port read_reg2  input  ADDR_W  rt address.
REQ-012 Port read_data1  output  DATA_W  contents addressed by read_reg1.
REQ-013 Port read_data2  output  DATA_W  contents addressed by read_reg2.
REQ-014 Port dbg_reg  input  ADDR_W  debug/observation address.
REQ-015 Port dbg_data  output  DATA_W  contents addressed by dbg_reg, with no bypass.

Function
REQ-016 Storage SHALL be 32 registers of DATA_W bits.
REQ-017 A write SHALL occur on the rising edge of clk when reg_write=1 and write_reg!=0; write_data is stored in register write_reg.
REQ-018 A write with write_reg=0 SHALL be discarded, so register 0 always reads 0.
REQ-019 Read ports SHALL be combinational, with zero-cycle latency from address to data.
REQ-020 Bypass: if reg_write=1, write_reg!=0 and read_regN==write_reg in the same cycle, read_dataN SHALL equal write_data (write-before-read).
REQ-021 Bypass SHALL be evaluated independently per port; both ports may bypass at once.
REQ-022 Reads of address 0 SHALL return 0 regardless of bypass conditions.
REQ-023 dbg_data SHALL return only the stored register value and SHALL NOT bypass.
REQ-024 Without reg_write=1, register contents SHALL be held indefinitely.
REQ-025 X or Z on write_reg while reg_write=0 SHALL NOT alter any register.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) set registers 28 to GP_INIT and 29 to SP_INIT, and all other registers to 0.
REQ-027 During reset, the read ports SHALL present the reset contents, and the bypass SHALL be suppressed.
REQ-028 A write coinciding with reset assertion SHALL be lost.
REQ-029 Reset release SHALL be synchronous to clk by the system; the first write is accepted on the first rising edge with rst_n=1.

Structure
REQ-030 Constants REG_ZERO=0, REG_GP=28, REG_SP=29, and the default widths SHALL live in the shared MIPS package, alongside the register-select definitions used by the destination-select mux.
REQ-031 A single sub-module, bypass_mux, SHALL implement the per-port forwarding compare/select; it SHALL be instantiated twice.
REQ-032 Storage SHALL be a flop array with an asynchronous clear, not inferred RAM, because of the non-uniform reset values.

Verification
REQ-033 Reset: assert rst_n=0 mid-cycle -> read_reg1=29 gives 0x00003FFC, read_reg2=28 gives 0x00001800, and registers 1–27 and 30–31 read 0 without a clock edge.
REQ-034 Write/read: write 0xDEADBEEF to register 8, then on the next cycle read_reg1=8 -> read_data1=0xDEADBEEF, and dbg_data (dbg_reg=8) matches.
REQ-035 Register 0: reg_write=1, write_reg=0, write_data=0xFFFFFFFF -> read_data1 (read_reg1=0) is 0 in the same cycle and every later cycle.
REQ-036 Bypass: write 0x12345678 to register 9 with read_reg1=read_reg2=9 in the same cycle -> both outputs are 0x12345678 before the edge; dbg_data (dbg_reg=9) shows the old value until after the edge.
REQ-037 Reset mid-operation: write 0xA5A5A5A5 to register 29, then pulse rst_n low between edges -> register 29 reads 0x00003FFC immediately.
REQ-038 Hold: reg_write=0 for 100 cycles with random addresses and data -> all registers unchanged; 1000 random write/read cycles match the reference model.
